// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// One operation is accepted per start pulse while idle; results commit after a fixed latency.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [1:0] {CLS_MUL, CLS_DIV, CLS_DIVZ} cls_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_p_q, hi_p_d, lo_p_q, lo_p_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic        sdiv;
    logic [31:0] num, den, quo_u, rem_u, quo, rem;

    // One shared magnitude divider serves both DIV and DIVU; signs are restored afterwards.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        sdiv   = (op == OP_DIV);
        num    = (sdiv && A[31]) ? -A : A;
        den    = (sdiv && B[31]) ? -B : B;
        if (den == 32'd0) begin
            den = 32'd1;
        end
        quo_u  = num / den;
        rem_u  = num % den;
        quo    = (sdiv && (A[31] ^ B[31])) ? -quo_u : quo_u;
        rem    = (sdiv && A[31]) ? -rem_u : rem_u;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {hi_p_d, lo_p_d} = prod_s;
                            cls_d   = CLS_MUL;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            {hi_p_d, lo_p_d} = prod_u;
                            cls_d   = CLS_MUL;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_p_d  = rem;
                            lo_p_d  = quo;
                            cls_d   = (B == 32'd0) ? CLS_DIVZ : CLS_DIV;
                            cnt_d   = DIV_CNT;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    // A divide by zero still burns its cycles but leaves HI/LO untouched.
                    if (cls_q != CLS_DIVZ) begin
                        hi_d = hi_p_q;
                        lo_d = lo_p_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_MUL;
            cnt_q   <= 4'd0;
            hi_p_q  <= 32'd0;
            lo_p_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO snapshots, a monitor checks them.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a_in = 32'd0, b_in = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .A(a_in), .B(b_in), .busy(busy), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    int          busy_end = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Monitor: pops expectations when due; flags unexpected busy drops and HI/LO motion during busy.
    logic        busy_prev = 1'b0;
    logic [31:0] hi_prev = 32'd0, lo_prev = 32'd0;
    int          rise_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        bit popped;
        popped = 1'b0;
        while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            check({e.name, "_busy"}, {31'd0, busy}, 32'd0);
            if (e.len > 0) check({e.name, "_busy_len"}, 32'(cyc - rise_cyc), 32'(e.len));
            popped = 1'b1;
        end
        if (busy_prev === 1'b1 && busy === 1'b0 && !popped) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_busy_drop at cycle %0d: got busy=0 expected busy=1", cyc);
        end
        if (busy_prev === 1'b1 && busy === 1'b1) begin
            check("hi_stable_while_busy", hi, hi_prev);
            check("lo_stable_while_busy", lo, lo_prev);
        end
        if (busy_prev !== 1'b1 && busy === 1'b1) rise_cyc = cyc;
        busy_prev = busy;
        hi_prev   = hi;
        lo_prev   = lo;
    end

    // One clock of stimulus; the reference model decides what the next edge does.
    task automatic step(input bit rst, input bit st, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
        int e;
        exp_t x;
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     rh, rl;
        @(posedge clk);
        #1;
        rst_n = ~rst;
        start = st;
        op    = o;
        a_in  = a;
        b_in  = b;
        e     = cyc + 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (rst) begin
            q.delete();
            m_hi = 32'd0;
            m_lo = 32'd0;
            busy_end = -1;
            x = '{due: e, hi: 32'd0, lo: 32'd0, len: 0, name: "reset"};
            q.push_back(x);
        end else if (st && e > busy_end) begin
            rh = m_hi;
            rl = m_lo;
            case (o)
                3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
                3'd1: begin p = ua * ub; rh = p[63:32]; rl = p[31:0]; end
                3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
                3'd3: if (b != 0) begin rl = a / b; rh = a % b; end
                3'd4: rh = a;
                3'd5: rl = a;
                default: ;
            endcase
            if (o <= 3'd1) begin
                busy_end = e + MC;
                x = '{due: busy_end, hi: rh, lo: rl, len: MC, name: "mult"};
                q.push_back(x);
            end else if (o <= 3'd3) begin
                busy_end = e + DC;
                x = '{due: busy_end, hi: rh, lo: rl, len: DC, name: (b == 0) ? "divz" : "div"};
                q.push_back(x);
            end else if (o <= 3'd5) begin
                x = '{due: e, hi: rh, lo: rl, len: 0, name: "mtx"};
                q.push_back(x);
            end
            m_hi = rh;
            m_lo = rl;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom(), $urandom());
    endtask

    initial begin
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        idle(1);
        step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3);
        idle(MC + 2);
        step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(MC + 2);
        step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(DC + 1);
        step(1'b0, 1'b1, 3'd3, 32'd7, 32'd0);
        idle(DC + 1);
        step(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC + 1);
        step(1'b0, 1'b1, 3'd4, 32'h1234_5678, 32'd0);
        idle(1);
        step(1'b0, 1'b1, 3'd2, 32'd1000, 32'hFFFF_FFF9);
        idle(2);
        step(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
        step(1'b0, 1'b1, 3'd4, 32'hCAFE_F00D, 32'd0);
        idle(DC);
        // Abort a divide on its fourth RUN cycle; nothing may commit afterwards.
        step(1'b0, 1'b1, 3'd3, 32'd99, 32'd4);
        idle(3);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        idle(DC + 4);
        for (int i = 0; i < 4 * (MC + 1); i++) step(1'b0, 1'b1, 3'd0, rnd_operand(), rnd_operand());
        idle(MC + 1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 299) == 0) step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
            else step(1'b0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
        end
        for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expectations expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the execute stage. It sits beside the ALU, upstream of the EX/MEM pipeline register, and owns the architectural HI/LO registers. The unit accepts one operation per start pulse and holds `busy` while the operation runs, so hazard logic can stall the decode stage. HI/LO values reach the EX/MEM register through the normal ALU-result mux (mfhi/mflo); this block does not drive that mux.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO commit (legal range 1–15)
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO commit (legal range 1–15)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous reset, active-low, sampled on posedge clk
- start  in  1  request; qualifies op and the operands this cycle
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6–7 reserved (no-op)
- A  in  32  rs operand, already forwarded
- B  in  32  rt operand, already forwarded
- busy  out  1  operation in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

## Operation
- State machine has two states, IDLE and RUN. Internal registers: a 4-bit down-counter `cnt`, 32-bit pending results `hi_p` and `lo_p`, and the pending op class.
- IDLE, start=1, op in 0–3:
  - Compute the result from A and B and latch it into hi_p/lo_p.
  - Load cnt with MULT_CYCLES or DIV_CYCLES, then go to RUN.
- IDLE, start=1, op=4: HI<=A at this edge. op=5: LO<=A at this edge. No busy, state stays IDLE.
- IDLE, start=1, op 6–7: no effect.
- RUN: cnt decrements every cycle. On the edge where cnt goes 1→0, HI<=hi_p, LO<=lo_p, and state goes to IDLE.
- A start received in RUN is ignored for every op, including MTHI/MTLO. The stall logic guarantees this never happens; the ignore behaviour is still required.
- MULT: signed 32×32→64 product; {HI,LO}=product.
- MULTU: same as MULT, unsigned.
- DIV, signed:
  - LO = quotient truncated toward zero.
  - HI = remainder, with the sign of the dividend A.
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU, unsigned: LO=A/B, HI=A%B.
- Divide by zero (DIV/DIVU with B=0): the operation runs its full DIV_CYCLES with busy asserted. HI/LO are left unchanged at commit.
- busy = (state==RUN), a registered output.
- HI/LO never change mid-operation; outputs always show the last committed values.

## Timing
- Reset (rst_n=0 at a posedge): HI=0, LO=0, busy=0, state=IDLE, cnt=0, hi_p=lo_p=0. Reset overrides start in the same cycle.
- Reset during RUN aborts the operation. Nothing is committed and HI/LO go to 0.
- A mult accepted at edge T:
  - busy=1 after T, through the cycle before edge T+MULT_CYCLES.
  - HI/LO update and busy falls at edge T+MULT_CYCLES.
  - busy is high for exactly MULT_CYCLES cycles. Division uses DIV_CYCLES the same way.
- Back-to-back: a start at the commit edge is not accepted, because the state is still RUN at that edge. The earliest next acceptance is the edge after busy falls.
- MTHI/MTLO: the value is visible on HI/LO in the cycle after the accepting edge. busy is never asserted.
- A and B are sampled only at the accepting edge. Later changes to A or B, or to start, have no effect on the pending result.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001. Confirm HI/LO are unchanged during busy.
- DIV A=0xFFFFFFF9 (−7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> busy for 10 cycles, HI/LO keep their prior values.
- MTHI A=0x12345678 -> HI=0x12345678 next cycle with busy=0. Issue MTLO while a DIV is in RUN -> LO changes only at the div commit, to the quotient.
- Start DIV, then pulse rst_n=0 at cycle 4 of RUN -> busy=0, HI=LO=0 after that edge, and no commit occurs later.
- Hold start=1 with MULT continuously -> exactly one acceptance per MULT_CYCLES+1 cycles; a gap of one idle cycle between busy periods.
